// File: rtl/de0ec8_pkg.sv
// Shared definitions for the de0ec8 reset sequencer: FSM state encoding
// and the bit positions of the reset-cause register.
package de0ec8_pkg;

  // Sequencer states; the encoding is fixed so it can be probed on a bus.
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  // Bit indices inside RST_CAUSE.
  localparam int CAUSE_PLL  = 0;
  localparam int CAUSE_BTN  = 1;
  localparam int CAUSE_SOFT = 2;
  localparam int CAUSE_W    = 3;

endpackage

// File: rtl/de0ec8_sync2.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable
// reset value so the synchronized signal starts in its "safe" state.
module de0ec8_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/de0ec8_rstgen.sv
// de0ec8 reset sequencer: waits for PLL lock, stretches the reset, then
// releases CH downstream resets one after another. PLL lock loss, a
// debounced push-button or a software request restart the sequence, and
// the reason for the last restart is kept in RST_CAUSE.
module de0ec8_rstgen
  import de0ec8_pkg::*;
#(
  parameter int CH       = 4,
  parameter int CNT_W    = 8,
  parameter int STRETCH  = 16,
  parameter int STAGE    = 16,
  parameter int DEB_W    = 16,
  parameter int SIM_FAST = 0
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          PLL_LOCKED,
  input  logic          BUTTON_N,
  input  logic          SOFT_RST,
  output logic [CH-1:0] RST_OUT_N,
  output logic          RST_DONE,
  output logic [2:0]    RST_CAUSE
);

  // Debounce length in cycles; the counter is one bit wider than DEB_W so
  // it can hold the full 2^DEB_W terminal value (and at least 4).
  localparam int DEB_LEN = (SIM_FAST != 0) ? 4 : (1 << DEB_W);
  localparam int DEB_CW  = (DEB_W + 1 > 3) ? DEB_W + 1 : 3;

  if (CH < 1 || CH > 8) begin : g_bad_ch
    $error("de0ec8_rstgen: CH must be in 1..8");
  end
  if (STRETCH < 1 || STRETCH >= (1 << CNT_W)) begin : g_bad_stretch
    $error("de0ec8_rstgen: STRETCH must be in 1..2^CNT_W-1");
  end
  if (STAGE < 1 || STAGE >= (1 << CNT_W)) begin : g_bad_stage
    $error("de0ec8_rstgen: STAGE must be in 1..2^CNT_W-1");
  end

  logic              lock_s;
  logic              btn_s;
  logic [DEB_CW-1:0] deb_cnt_q;
  logic              btn_press;
  logic              trigger;
  logic [CAUSE_W-1:0] cause_vec;

  state_t            state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [2:0]        ch_q, ch_nxt;
  logic [3:0]        ch_p1;
  logic [CH-1:0]     rst_out_n_q, rst_out_n_nxt;
  logic              rst_done_q, rst_done_nxt;
  logic [CAUSE_W-1:0] rst_cause_q, rst_cause_nxt;

  // Lock starts "not locked" and the button starts "released" out of reset.
  de0ec8_sync2 #(.RST_VAL(1'b0)) u_sync_lock (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     (PLL_LOCKED),
    .q     (lock_s)
  );

  de0ec8_sync2 #(.RST_VAL(1'b1)) u_sync_btn (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     (BUTTON_N),
    .q     (btn_s)
  );

  // Count how long the button has been held; saturate once it counts as a press.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      deb_cnt_q <= '0;
    end else if (btn_s) begin
      deb_cnt_q <= '0;
    end else if (!btn_press) begin
      deb_cnt_q <= deb_cnt_q + DEB_CW'(1);
    end
  end

  assign btn_press = (deb_cnt_q == DEB_CW'(DEB_LEN));
  assign trigger   = !lock_s || btn_press || SOFT_RST;
  assign ch_p1     = {1'b0, ch_q} + 4'd1;

  // Collect every currently active restart reason into one cause word.
  always_comb begin
    cause_vec             = '0;
    cause_vec[CAUSE_PLL]  = !lock_s;
    cause_vec[CAUSE_BTN]  = btn_press;
    cause_vec[CAUSE_SOFT] = SOFT_RST;
  end

  // Sequencer state, counters and all registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      ch_q        <= '0;
      rst_out_n_q <= '0;
      rst_done_q  <= 1'b0;
      rst_cause_q <= '0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      ch_q        <= ch_nxt;
      rst_out_n_q <= rst_out_n_nxt;
      rst_done_q  <= rst_done_nxt;
      rst_cause_q <= rst_cause_nxt;
    end
  end

  // Next-state logic: a trigger outside HOLD always wins over stage progress.
  always_comb begin
    state_nxt     = state_q;
    cnt_nxt       = cnt_q;
    ch_nxt        = ch_q;
    rst_out_n_nxt = rst_out_n_q;
    rst_done_nxt  = rst_done_q;
    rst_cause_nxt = rst_cause_q;

    if (state_q != ST_HOLD && trigger) begin
      state_nxt     = ST_HOLD;
      cnt_nxt       = '0;
      ch_nxt        = '0;
      rst_out_n_nxt = '0;
      rst_done_nxt  = 1'b0;
      rst_cause_nxt = cause_vec;
    end else begin
      case (state_q)
        ST_HOLD: begin
          cnt_nxt       = '0;
          ch_nxt        = '0;
          rst_out_n_nxt = '0;
          rst_done_nxt  = 1'b0;
          if (lock_s && btn_s && !SOFT_RST) begin
            state_nxt = ST_STRETCH;
          end
        end
        ST_STRETCH: begin
          if (cnt_q == CNT_W'(STRETCH - 1)) begin
            cnt_nxt       = '0;
            ch_nxt        = '0;
            rst_out_n_nxt = CH'(1);
            if (CH == 1) begin
              state_nxt    = ST_RUN;
              rst_done_nxt = 1'b1;
            end else begin
              state_nxt = ST_RELEASE;
            end
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == CNT_W'(STAGE - 1)) begin
            cnt_nxt       = '0;
            ch_nxt        = ch_p1[2:0];
            rst_out_n_nxt = rst_out_n_q | (CH'(1) << ch_p1);
            if (ch_p1 == 4'(CH - 1)) begin
              state_nxt    = ST_RUN;
              rst_done_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          state_nxt = ST_RUN;
        end
        default: begin
          state_nxt = ST_HOLD;
        end
      endcase
    end
  end

  assign RST_OUT_N = rst_out_n_q;
  assign RST_DONE  = rst_done_q;
  assign RST_CAUSE = rst_cause_q;

endmodule

// File: tb/tb_de0ec8_rstgen.sv
// Directed bench for de0ec8_rstgen. Three instances share clock and power-on
// reset: A uses the defaults, B is a fast 4-channel build (SIM_FAST,
// STRETCH=4, STAGE=3), C is the single-channel STRETCH=1 corner. Expected
// outputs are queued with the edge number at which they must be seen.
module tb_de0ec8_rstgen;

  localparam int SEL_LOCK_A = 0;
  localparam int SEL_LOCK_B = 1;
  localparam int SEL_BTN_B  = 2;
  localparam int SEL_SOFT_B = 3;
  localparam int SEL_SOFT_C = 4;

  typedef struct {
    string      tag;
    int         unit_id;
    int         at_edge;
    logic [3:0] out;
    logic       done;
    logic [2:0] cause;
  } exp_t;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  logic       lock_a = 1'b1, btn_a = 1'b1, soft_a = 1'b0;
  logic       lock_b = 1'b1, btn_b = 1'b1, soft_b = 1'b0;
  logic       lock_c = 1'b1, btn_c = 1'b1, soft_c = 1'b0;
  logic [3:0] out_a, out_b;
  logic [0:0] out_c;
  logic       done_a, done_b, done_c;
  logic [2:0] cause_a, cause_b, cause_c;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   edge_no = 0;

  always #5 CLK = ~CLK;

  de0ec8_rstgen #(.SIM_FAST(0)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .PLL_LOCKED(lock_a), .BUTTON_N(btn_a),
    .SOFT_RST(soft_a), .RST_OUT_N(out_a), .RST_DONE(done_a), .RST_CAUSE(cause_a)
  );

  de0ec8_rstgen #(.CH(4), .STRETCH(4), .STAGE(3), .SIM_FAST(1)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .PLL_LOCKED(lock_b), .BUTTON_N(btn_b),
    .SOFT_RST(soft_b), .RST_OUT_N(out_b), .RST_DONE(done_b), .RST_CAUSE(cause_b)
  );

  de0ec8_rstgen #(.CH(1), .STRETCH(1), .STAGE(1), .SIM_FAST(1)) dut_c (
    .CLK(CLK), .RST_N(RST_N), .PLL_LOCKED(lock_c), .BUTTON_N(btn_c),
    .SOFT_RST(soft_c), .RST_OUT_N(out_c), .RST_DONE(done_c), .RST_CAUSE(cause_c)
  );

  // Edge 1 is the first rising edge with RST_N high.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) edge_no <= 0;
    else        edge_no <= edge_no + 1;
  end

  function automatic exp_t mk(input string tag, input int u, input int at,
                              input logic [3:0] o, input logic d, input logic [2:0] c);
    exp_t e;
    e.tag = tag; e.unit_id = u; e.at_edge = at; e.out = o; e.done = d; e.cause = c;
    return e;
  endfunction

  task automatic expectAt(input string tag, input int u, input int at,
                          input logic [3:0] o, input logic d, input logic [2:0] c);
    sb.push_back(mk(tag, u, at, o, d, c));
  endtask

  task automatic checkOutput(input exp_t e);
    logic [3:0] o;
    logic       d;
    logic [2:0] c;
    case (e.unit_id)
      0:       begin o = out_a;           d = done_a; c = cause_a; end
      1:       begin o = out_b;           d = done_b; c = cause_b; end
      default: begin o = {3'b000, out_c}; d = done_c; c = cause_c; end
    endcase
    checks++;
    assert (o === e.out) else begin
      errors++;
      $error("[TB] FAIL %s rst_out_n got %b want %b", e.tag, o, e.out);
    end
    checks++;
    assert (d === e.done) else begin
      errors++;
      $error("[TB] FAIL %s rst_done got %b want %b", e.tag, d, e.done);
    end
    checks++;
    assert (c === e.cause) else begin
      errors++;
      $error("[TB] FAIL %s rst_cause got %b want %b", e.tag, c, e.cause);
    end
  endtask

  task automatic goto_edge(input int e);
    int guard = 0;
    while (edge_no < e && guard < 5000) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    if (edge_no < e) begin
      checks++;
      errors++;
      $display("[TB] FAIL goto_edge reached %0d want %0d", edge_no, e);
    end
  endtask

  task automatic applyStimulus(input int at, input int sel, input logic v);
    goto_edge(at);
    case (sel)
      SEL_LOCK_A: lock_a = v;
      SEL_LOCK_B: lock_b = v;
      SEL_BTN_B:  btn_b  = v;
      SEL_SOFT_B: soft_b = v;
      default:    soft_c = v;
    endcase
  endtask

  // Scoreboard: compare every queued expectation at its edge, 1 time unit after it.
  always begin
    @(posedge CLK);
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (RST_N && sb[i].at_edge == edge_no) begin
        checkOutput(sb[i]);
        sb.delete(i);
      end
    end
  end

  initial begin
    exp_t left;
    $display("[TB] de0ec8_rstgen bench start");
    repeat (3) @(posedge CLK);
    #1;
    checkOutput(mk("reset_a", 0, 0, 4'b0000, 1'b0, 3'b000));
    checkOutput(mk("reset_b", 1, 0, 4'b0000, 1'b0, 3'b000));
    checkOutput(mk("reset_c", 2, 0, 4'b0000, 1'b0, 3'b000));

    // Power-on sequences of all three builds.
    expectAt("c_pre",   2, 3,  4'b0000, 1'b0, 3'b000);
    expectAt("c_rel",   2, 4,  4'b0001, 1'b1, 3'b000);
    expectAt("b_pre0",  1, 6,  4'b0000, 1'b0, 3'b000);
    expectAt("b_rel0",  1, 7,  4'b0001, 1'b0, 3'b000);
    expectAt("b_pre1",  1, 9,  4'b0001, 1'b0, 3'b000);
    expectAt("b_rel1",  1, 10, 4'b0011, 1'b0, 3'b000);
    expectAt("b_rel2",  1, 13, 4'b0111, 1'b0, 3'b000);
    expectAt("b_pre3",  1, 15, 4'b0111, 1'b0, 3'b000);
    expectAt("b_rel3",  1, 16, 4'b1111, 1'b1, 3'b000);
    expectAt("a_pre0",  0, 18, 4'b0000, 1'b0, 3'b000);
    expectAt("a_rel0",  0, 19, 4'b0001, 1'b0, 3'b000);
    expectAt("a_pre1",  0, 34, 4'b0001, 1'b0, 3'b000);
    expectAt("a_rel1",  0, 35, 4'b0011, 1'b0, 3'b000);
    expectAt("a_rel2",  0, 51, 4'b0111, 1'b0, 3'b000);
    expectAt("a_pre3",  0, 66, 4'b0111, 1'b0, 3'b000);
    expectAt("a_rel3",  0, 67, 4'b1111, 1'b1, 3'b000);
    // Button glitch ignored, then a real press and the restart after release.
    expectAt("b_glitch", 1, 27, 4'b1111, 1'b1, 3'b000);
    expectAt("b_btn_pre", 1, 36, 4'b1111, 1'b1, 3'b000);
    expectAt("b_btn_hit", 1, 37, 4'b0000, 1'b0, 3'b010);
    expectAt("b_btn_hold", 1, 46, 4'b0000, 1'b0, 3'b010);
    expectAt("b_btn_rel0", 1, 47, 4'b0001, 1'b0, 3'b010);
    expectAt("b_btn_done", 1, 56, 4'b1111, 1'b1, 3'b010);
    // Soft resets: one from RUN, one on the edge channel 1 would release.
    expectAt("b_soft_pre", 1, 59, 4'b1111, 1'b1, 3'b010);
    expectAt("b_soft_hit", 1, 60, 4'b0000, 1'b0, 3'b100);
    expectAt("b_soft_rel0", 1, 65, 4'b0001, 1'b0, 3'b100);
    expectAt("b_soft_ch1", 1, 68, 4'b0000, 1'b0, 3'b100);
    expectAt("b_soft_again1", 1, 76, 4'b0011, 1'b0, 3'b100);
    expectAt("b_soft_done", 1, 82, 4'b1111, 1'b1, 3'b100);
    // PLL drop on A while running.
    expectAt("a_pll_pre", 0, 72, 4'b1111, 1'b1, 3'b000);
    expectAt("a_pll_hit", 0, 73, 4'b0000, 1'b0, 3'b001);
    expectAt("a_pll_pre0", 0, 89, 4'b0000, 1'b0, 3'b001);
    expectAt("a_pll_rel0", 0, 90, 4'b0001, 1'b0, 3'b001);
    expectAt("a_pll_pre1", 0, 105, 4'b0001, 1'b0, 3'b001);
    expectAt("a_pll_rel1", 0, 106, 4'b0011, 1'b0, 3'b001);
    // Soft coincident with synchronized lock loss on B.
    expectAt("b_both_pre", 1, 92, 4'b1111, 1'b1, 3'b100);
    expectAt("b_both_hit", 1, 93, 4'b0000, 1'b0, 3'b101);
    expectAt("b_both_rel0", 1, 98, 4'b0001, 1'b0, 3'b101);
    expectAt("b_both_done", 1, 107, 4'b1111, 1'b1, 3'b101);
    // Soft reset on the single-channel build.
    expectAt("c_soft_pre", 2, 99, 4'b0001, 1'b1, 3'b000);
    expectAt("c_soft_hit", 2, 100, 4'b0000, 1'b0, 3'b100);
    expectAt("c_soft_hold", 2, 101, 4'b0000, 1'b0, 3'b100);
    expectAt("c_soft_rel", 2, 102, 4'b0001, 1'b1, 3'b100);

    RST_N = 1'b1;

    applyStimulus(20, SEL_BTN_B, 1'b0);
    applyStimulus(23, SEL_BTN_B, 1'b1);
    applyStimulus(30, SEL_BTN_B, 1'b0);
    applyStimulus(40, SEL_BTN_B, 1'b1);
    applyStimulus(59, SEL_SOFT_B, 1'b1);
    applyStimulus(60, SEL_SOFT_B, 1'b0);
    applyStimulus(67, SEL_SOFT_B, 1'b1);
    applyStimulus(68, SEL_SOFT_B, 1'b0);
    applyStimulus(70, SEL_LOCK_A, 1'b0);
    applyStimulus(71, SEL_LOCK_A, 1'b1);
    applyStimulus(90, SEL_LOCK_B, 1'b0);
    applyStimulus(91, SEL_LOCK_B, 1'b1);
    applyStimulus(92, SEL_SOFT_B, 1'b1);
    applyStimulus(93, SEL_SOFT_B, 1'b0);
    applyStimulus(99, SEL_SOFT_C, 1'b1);
    applyStimulus(100, SEL_SOFT_C, 1'b0);

    // Power-on reset in the middle of A's RELEASE phase, away from any edge.
    goto_edge(110);
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput(mk("async_a", 0, 0, 4'b0000, 1'b0, 3'b000));
    checkOutput(mk("async_b", 1, 0, 4'b0000, 1'b0, 3'b000));
    checkOutput(mk("async_c", 2, 0, 4'b0000, 1'b0, 3'b000));

    // Second power-on must look exactly like the first one.
    expectAt("a2_pre0", 0, 18, 4'b0000, 1'b0, 3'b000);
    expectAt("a2_rel0", 0, 19, 4'b0001, 1'b0, 3'b000);
    expectAt("b2_rel0", 1, 7,  4'b0001, 1'b0, 3'b000);
    expectAt("c2_pre",  2, 3,  4'b0000, 1'b0, 3'b000);
    expectAt("c2_rel",  2, 4,  4'b0001, 1'b1, 3'b000);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    goto_edge(20);

    while (sb.size() > 0) begin
      left = sb.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s never observed at edge %0d", left.tag, left.at_edge);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/de0ec8_rstgen.md
# de0ec8_rstgen

Parametrised reset sequencer for de0ec8 designs. It replaces the fixed 8-bit "count to 0x0f, then release" stretcher with a synthesisable block that has:
- CH independently staged reset outputs;
- PLL-lock gating;
- a debounced push-button reset and a software reset request;
- a sticky reset-cause register.

It sits directly behind the board clock/PLL and drives every downstream subsystem reset (SDRAM controller, video, CPU core, ...).

## Interface
Parameters:
- CH, 4: number of reset output channels (1..8).
- CNT_W, 8: width of the stretch/stage counter.
- STRETCH, 16: cycles from lock-qualified start to release of channel 0 (1..2^CNT_W-1).
- STAGE, 16: cycles between release of channel k and channel k+1 (1..2^CNT_W-1).
- DEB_W, 16: debounce counter width. A button press must be stable for 2^DEB_W cycles.
- SIM_FAST, 0: 1 forces the debounce length to 4 cycles.

Ports:
- CLK, in, 1: system clock.
- RST_N, in, 1: asynchronous, active-low power-on reset. One clock; reset is asynchronous and active-low.
- PLL_LOCKED, in, 1: asynchronous PLL lock indication.
- BUTTON_N, in, 1: asynchronous push-button, low = pressed.
- SOFT_RST, in, 1: synchronous single-cycle reset request.
- RST_OUT_N, out, CH: per-channel active-low reset, registered.
- RST_DONE, out, 1: all channels released.
- RST_CAUSE, out, 3: last trigger. [0] PLL lock loss, [1] button, [2] soft.

## Operation
- PLL_LOCKED and BUTTON_N each pass through a 2-flop synchronizer (lock_s, btn_s). Synchronizer reset value is 0 for lock_s and 1 for btn_s.
- Debounce:
  - The counter increments while btn_s=0 and clears while btn_s=1.
  - btn_press is asserted while the count has reached its terminal value.
  - The counter saturates at the terminal value; it does not wrap.
- FSM states:
  - HOLD: all RST_OUT_N=0, RST_DONE=0. Move to STRETCH when lock_s=1, btn_s=1 and SOFT_RST=0. On entry, cnt=0.
  - STRETCH: cnt increments. At cnt==STRETCH-1, go to RELEASE with ch=0 and cnt=0, and set RST_OUT_N[0]=1.
  - RELEASE: cnt increments. At cnt==STAGE-1, set RST_OUT_N[ch+1]=1, increment ch and clear cnt. When ch+1==CH-1 is released, go to RUN and set RST_DONE=1 on the same edge. If CH=1, STRETCH goes directly to RUN.
  - RUN: outputs held.
- Trigger = !lock_s | btn_press | SOFT_RST.
  - A trigger in STRETCH, RELEASE or RUN moves the FSM to HOLD.
  - On that edge, all RST_OUT_N=0 and RST_DONE=0.
  - RST_CAUSE is loaded with the OR of all active trigger bits, so simultaneous causes set several bits.
- A trigger while already in HOLD does not change RST_CAUSE.
- Released channels stay released (monotonic) until the next HOLD.
- RST_N low at any time, including mid-sequence: asynchronously forces HOLD, RST_OUT_N=0, RST_DONE=0, RST_CAUSE=0, counters 0.

## Timing
- Reset values: RST_OUT_N=0, RST_DONE=0, RST_CAUSE=3'b000.
- Edge numbering: edge 1 is the first rising CLK edge with RST_N=1. PLL_LOCKED=1 and BUTTON_N=1 are stable throughout.
  - lock_s=1 after edge 2.
  - HOLD→STRETCH at edge 3.
  - RST_OUT_N[k] rises at edge 3+STRETCH+k·STAGE.
  - RST_DONE rises at the same edge as RST_OUT_N[CH-1].
- Defaults (CH=4, STRETCH=16, STAGE=16): channel releases at edges 19, 35, 51 and 67. RST_DONE rises at edge 67.
- Trigger-to-assert latency:
  - SOFT_RST: 1 edge.
  - PLL loss: 3 edges (2 sync + 1).
  - Button: 2 sync edges + debounce length + 1.
- Restart after a trigger: the same sequence as power-on, counted from the edge on which the HOLD exit condition is first true.

## Structure
- Shared package de0ec8_pkg:
  - FSM state localparams: HOLD=2'd0, STRETCH=2'd1, RELEASE=2'd2, RUN=2'd3.
  - RST_CAUSE bit indices.
- Sub-module de0ec8_sync2: 2-flop synchronizer, parametrised reset value. Instantiated twice.
- Elaboration check: STRETCH, STAGE < 2^CNT_W, and CH ≤ 8.

## Test plan
- Power-on with defaults, lock and button high → releases at edges 19, 35, 51, 67. RST_DONE at 67. RST_CAUSE=000.
- PLL_LOCKED dropped for 1 cycle while in RUN → all RST_OUT_N=0 at the 3rd edge after the drop. RST_CAUSE=001. Full re-sequence follows.
- SIM_FAST=1: 3-cycle BUTTON_N low glitch → no reset. 10-cycle press → reset with RST_CAUSE=010. Release waits until btn_s=1.
- SOFT_RST pulse on the same edge that RST_OUT_N[1] would rise → RST_OUT_N[1] stays 0, all outputs return to 0, RST_CAUSE=100.
- SOFT_RST coincident with synced lock loss → RST_CAUSE=101.
- RST_N asserted mid-RELEASE → outputs 0 immediately (no clock), RST_CAUSE=000. CH=1, STRETCH=1 corner: RST_OUT_N[0] and RST_DONE rise at edge 4.
